qtt_adc_cmp: RTL and testbench



---
 rtl/qtt_adc_cmp.sv | 155 +++++++++++++++
 tb/tb_qtt_adc_cmp.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qtt_adc_cmp.sv
// Per-ADC threshold-crossing detector: invert/filter, rising-edge compare and
// time-tag generation with arm gating and a post-tag inhibit window.
module qtt_adc_cmp #(
   parameter int SMP_DW = 16,
   parameter int SMP_CK = 8,
   parameter int INH_W  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       arm_i,
   input  logic                       cfg_invert_i,
   input  logic                       cfg_filter_i,
   input  logic [SMP_DW-1:0]          cmp_th_i,
   input  logic [INH_W-1:0]           cmp_inh_i,
   input  logic                       adc_vld_i,
   input  logic [SMP_CK*SMP_DW-1:0]   adc_dt_i,
   output logic                       tag_vld_o,
   output logic [31:0]                tag_dt_o,
   output logic [CNT_W-1:0]           tag_cnt_o,
   output logic                       prev_vld_o
);

   localparam int IW = $clog2(SMP_CK);
   localparam int CW = 32 - IW;

   typedef logic signed [SMP_DW-1:0] smp_t;

   localparam smp_t SMP_MIN = {1'b1, {(SMP_DW-1){1'b0}}};
   localparam smp_t SMP_MAX = {1'b0, {(SMP_DW-1){1'b1}}};

   logic [CW-1:0]          coarse;
   logic [INH_W-1:0]       inh_cnt;

   // stage 1 state
   logic                   s1_vld;
   logic                   s1_arm;
   logic [CW-1:0]          s1_coarse;
   smp_t                   s1_th;
   smp_t                   s1_y [SMP_CK];
   smp_t                   x_prev;

   // stage 2 state
   logic                   s2_vld;
   logic                   s2_arm;
   logic [CW-1:0]          s2_coarse;
   logic [SMP_CK-1:0]      s2_c;
   smp_t                   y_prev;
   logic                   y_seen;

   smp_t                   x_ext [SMP_CK+1];
   smp_t                   y_in  [SMP_CK];
   logic signed [SMP_DW:0] sum_f [SMP_CK];
   smp_t                   y_ext [SMP_CK+1];
   logic [SMP_CK-1:0]      c_nxt;
   logic [IW-1:0]          idx;
   logic                   fire;

   // Element 0 of the extended arrays is the carried-over sample from the last valid beat.
   always_comb begin
      x_ext[0] = x_prev;
      for (int k = 0; k < SMP_CK; k++) begin
         x_ext[k+1] = adc_dt_i[k*SMP_DW +: SMP_DW];
         if (cfg_invert_i) begin
            x_ext[k+1] = (x_ext[k+1] == SMP_MIN) ? SMP_MAX : -x_ext[k+1];
         end
      end
      for (int k = 0; k < SMP_CK; k++) begin
         sum_f[k] = {x_ext[k+1][SMP_DW-1], x_ext[k+1]} + {x_ext[k][SMP_DW-1], x_ext[k]};
         y_in[k]  = cfg_filter_i ? smp_t'(sum_f[k][SMP_DW:1]) : x_ext[k+1];
      end
   end

   always_comb begin
      y_ext[0] = y_prev;
      for (int k = 0; k < SMP_CK; k++) begin
         y_ext[k+1] = s1_y[k];
      end
      for (int k = 0; k < SMP_CK; k++) begin
         c_nxt[k] = (y_ext[k+1] > s1_th) && (y_ext[k] <= s1_th);
      end
      c_nxt[0] = c_nxt[0] & y_seen;
   end

   always_comb begin
      idx = '0;
      for (int k = SMP_CK-1; k >= 0; k--) begin
         if (s2_c[k]) idx = IW'(k);
      end
      fire = s2_vld && s2_arm && (|s2_c) && (inh_cnt == '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         coarse     <= '0;
         s1_vld     <= 1'b0;
         s1_arm     <= 1'b0;
         s1_coarse  <= '0;
         s1_th      <= '0;
         x_prev     <= '0;
         prev_vld_o <= 1'b0;
         for (int k = 0; k < SMP_CK; k++) s1_y[k] <= '0;
      end else begin
         coarse    <= coarse + CW'(1);
         s1_vld    <= adc_vld_i;
         s1_arm    <= arm_i;
         s1_coarse <= coarse;
         s1_th     <= cmp_th_i;
         if (adc_vld_i) begin
            for (int k = 0; k < SMP_CK; k++) s1_y[k] <= y_in[k];
            x_prev     <= x_ext[SMP_CK];
            prev_vld_o <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s2_vld    <= 1'b0;
         s2_arm    <= 1'b0;
         s2_coarse <= '0;
         s2_c      <= '0;
         y_prev    <= '0;
         y_seen    <= 1'b0;
      end else begin
         s2_vld    <= s1_vld;
         s2_arm    <= s1_arm;
         s2_coarse <= s1_coarse;
         s2_c      <= s1_vld ? c_nxt : '0;
         if (s1_vld) begin
            y_prev <= s1_y[SMP_CK-1];
            y_seen <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tag_vld_o <= 1'b0;
         tag_dt_o  <= '0;
         tag_cnt_o <= '0;
         inh_cnt   <= '0;
      end else begin
         tag_vld_o <= fire;
         if (fire) begin
            tag_dt_o <= {s2_coarse, idx};
            if (tag_cnt_o != '1) tag_cnt_o <= tag_cnt_o + CNT_W'(1);
            inh_cnt  <= cmp_inh_i;
         end else if (inh_cnt != '0) begin
            inh_cnt  <= inh_cnt - INH_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_qtt_adc_cmp.sv
// Scoreboard bench for qtt_adc_cmp: a behavioural model queues the expected
// output of every beat, compared three cycles later.
module tb_qtt_adc_cmp;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          arm_i = 1'b0;
   logic          cfg_invert_i = 1'b0;
   logic          cfg_filter_i = 1'b0;
   logic [15:0]   cmp_th_i = '0;
   logic [7:0]    cmp_inh_i = '0;
   logic          adc_vld_i = 1'b0;
   logic [127:0]  adc_dt_i = '0;
   logic          tag_vld_o;
   logic [31:0]   tag_dt_o;
   logic [15:0]   tag_cnt_o;
   logic          prev_vld_o;

   qtt_adc_cmp dut (
      .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i),
      .cfg_invert_i(cfg_invert_i), .cfg_filter_i(cfg_filter_i),
      .cmp_th_i(cmp_th_i), .cmp_inh_i(cmp_inh_i),
      .adc_vld_i(adc_vld_i), .adc_dt_i(adc_dt_i),
      .tag_vld_o(tag_vld_o), .tag_dt_o(tag_dt_o),
      .tag_cnt_o(tag_cnt_o), .prev_vld_o(prev_vld_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit          vld;
      logic [31:0] dt;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   int n_chk = 0;
   int n_pass = 0;
   int n_tags = 0;
   logic [31:0] last_dt = '0;

   // stimulus and configuration seen by both DUT and model
   int bt[8];
   bit inv = 0, filt = 0;
   int th = 100, inh = 0;

   // model state
   int xp, yp, inh_m, cnt_m;
   bit seen;
   logic [28:0] coarse_m;

   task automatic set_beat(input int a0, a1, a2, a3, a4, a5, a6, a7);
      bt[0] = a0; bt[1] = a1; bt[2] = a2; bt[3] = a3;
      bt[4] = a4; bt[5] = a5; bt[6] = a6; bt[7] = a7;
   endtask

   task automatic cycle(input bit vld, input bit arm);
      exp_t e;
      int x[8], y[8];
      int p, ypr, idx;
      bit found, fire;
      @(negedge clk_i);
      if (q.size() == 3) begin
         e = q.pop_front();
         n_chk++;
         if (tag_vld_o !== e.vld)
            $display("FAIL tag_vld t=%0t got %b exp %b", $time, tag_vld_o, e.vld);
         else n_pass++;
         if (e.vld) begin
            n_tags++;
            last_dt = tag_dt_o;
            n_chk++;
            if (tag_dt_o !== e.dt)
               $display("FAIL tag_dt t=%0t got %h exp %h", $time, tag_dt_o, e.dt);
            else n_pass++;
         end
         n_chk++;
         if (tag_cnt_o !== e.cnt)
            $display("FAIL tag_cnt t=%0t got %h exp %h", $time, tag_cnt_o, e.cnt);
         else n_pass++;
      end
      adc_vld_i    = vld;
      arm_i        = arm;
      cfg_invert_i = inv;
      cfg_filter_i = filt;
      cmp_th_i     = 16'(th);
      cmp_inh_i    = 8'(inh);
      for (int k = 0; k < 8; k++) adc_dt_i[k*16 +: 16] = 16'(bt[k]);
      fire = 0;
      idx  = 0;
      if (vld) begin
         for (int k = 0; k < 8; k++)
            x[k] = inv ? ((bt[k] == -32768) ? 32767 : -bt[k]) : bt[k];
         for (int k = 0; k < 8; k++) begin
            p = (k == 0) ? xp : x[k-1];
            y[k] = filt ? ((x[k] + p) >>> 1) : x[k];
         end
         found = 0;
         for (int k = 0; k < 8; k++) begin
            ypr = (k == 0) ? yp : y[k-1];
            if (!found && y[k] > th && ypr <= th && (k > 0 || seen)) begin
               found = 1;
               idx = k;
            end
         end
         fire = found && arm && (inh_m == 0);
         xp = x[7];
         yp = y[7];
         seen = 1;
      end
      if (fire) inh_m = inh;
      else if (inh_m > 0) inh_m--;
      if (fire && cnt_m < 65535) cnt_m++;
      e.vld = fire;
      e.dt  = {coarse_m, 3'(idx)};
      e.cnt = 16'(cnt_m);
      q.push_back(e);
      coarse_m++;
   endtask

   task automatic flush(input int n);
      set_beat(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (n) cycle(1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      adc_vld_i = 1'b0;
      arm_i = 1'b0;
      @(negedge clk_i);
      n_chk++;
      if ({tag_vld_o, tag_dt_o, tag_cnt_o, prev_vld_o} !== '0)
         $display("FAIL reset_outputs got vld=%b dt=%h cnt=%h pv=%b exp all 0",
                  tag_vld_o, tag_dt_o, tag_cnt_o, prev_vld_o);
      else n_pass++;
      rst_i = 1'b0;
      q.delete();
      xp = 0; yp = 0; seen = 0; inh_m = 0; cnt_m = 0;
      coarse_m = 29'd1;
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_basic();
      inv = 0; filt = 0; th = 100; inh = 0;
      do_reset();
      set_beat(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (4) cycle(1'b1, 1'b1);
      set_beat(0, 0, 0, 200, 200, 0, 0, 0);
      n_tags = 0;
      cycle(1'b1, 1'b1);
      flush(4);
      n_chk++;
      if (n_tags != 1 || last_dt !== 32'h2B)
         $display("FAIL basic_tag got n=%0d dt=%h exp n=1 dt=0000002b", n_tags, last_dt);
      else n_pass++;
      n_chk++;
      if (tag_cnt_o !== 16'd1) $display("FAIL basic_cnt got %0d exp 1", tag_cnt_o);
      else n_pass++;
   endtask

   task automatic test_first_beat();
      do_reset();
      n_tags = 0;
      set_beat(500, 0, 0, 0, 0, 0, 0, 0);
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      n_chk++;
      if (prev_vld_o !== 1'b1) $display("FAIL prev_vld got %b exp 1", prev_vld_o);
      else n_pass++;
      flush(4);
      n_chk++;
      if (n_tags != 1 || last_dt[2:0] !== 3'd0)
         $display("FAIL first_beat got n=%0d idx=%0d exp n=1 idx=0", n_tags, last_dt[2:0]);
      else n_pass++;
   endtask

   task automatic test_inhibit();
      inh = 2;
      do_reset();
      n_tags = 0;
      set_beat(0, 200, 0, 200, 0, 200, 0, 200);
      repeat (7) cycle(1'b1, 1'b1);
      flush(4);
      n_chk++;
      if (n_tags != 3) $display("FAIL inhibit_tags got %0d exp 3", n_tags);
      else n_pass++;
      inh = 0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      n_tags = 0;
      set_beat(0, 200, 0, 200, 0, 200, 0, 200);
      repeat (5) cycle(1'b1, 1'b1);
      flush(4);
      n_chk++;
      if (n_tags != 5) $display("FAIL back_to_back got %0d exp 5", n_tags);
      else n_pass++;
   endtask

   task automatic test_invert_filter();
      do_reset();
      inv = 1; th = 100;
      n_tags = 0;
      set_beat(0, 0, -32768, 0, 0, 0, 0, 0);
      cycle(1'b1, 1'b1);
      flush(4);
      n_chk++;
      if (n_tags != 1 || last_dt[2:0] !== 3'd2)
         $display("FAIL invert_sat got n=%0d idx=%0d exp n=1 idx=2", n_tags, last_dt[2:0]);
      else n_pass++;
      inv = 0; filt = 1;
      n_tags = 0;
      set_beat(0, 0, 0, 300, 0, 0, 0, 0);
      cycle(1'b1, 1'b1);
      flush(4);
      n_chk++;
      if (n_tags != 1 || last_dt[2:0] !== 3'd3)
         $display("FAIL filter_idx got n=%0d idx=%0d exp n=1 idx=3", n_tags, last_dt[2:0]);
      else n_pass++;
      filt = 0;
   endtask

   task automatic test_arm_gap();
      logic [28:0] cb;
      do_reset();
      n_tags = 0;
      set_beat(0, 200, 0, 0, 0, 0, 0, 0);
      repeat (4) cycle(1'b1, 1'b0);
      cb = coarse_m;
      cycle(1'b1, 1'b1);
      flush(4);
      n_chk++;
      if (n_tags != 1 || last_dt !== {cb, 3'd1})
         $display("FAIL arm_first got n=%0d dt=%h exp n=1 dt=%h", n_tags, last_dt, {cb, 3'd1});
      else n_pass++;
      n_tags = 0;
      set_beat(0, 0, 0, 0, 0, 0, 0, 0);
      cycle(1'b1, 1'b1);
      set_beat(500, 500, 500, 500, 500, 500, 500, 500);
      repeat (3) cycle(1'b0, 1'b1);
      set_beat(200, 0, 0, 0, 0, 0, 0, 0);
      cycle(1'b1, 1'b1);
      flush(4);
      n_chk++;
      if (n_tags != 1 || last_dt[2:0] !== 3'd0)
         $display("FAIL gap_idx0 got n=%0d idx=%0d exp n=1 idx=0", n_tags, last_dt[2:0]);
      else n_pass++;
   endtask

   task automatic test_reset_midflight();
      do_reset();
      set_beat(0, 0, 0, 0, 200, 0, 0, 0);
      cycle(1'b1, 1'b1);
      flush(1);
      do_reset();
      n_tags = 0;
      flush(5);
      n_chk++;
      if (n_tags != 0 || tag_cnt_o !== 16'd0)
         $display("FAIL reset_drop got n=%0d cnt=%0d exp 0", n_tags, tag_cnt_o);
      else n_pass++;
   endtask

   task automatic test_random();
      inh = 1;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         inv  = ($urandom_range(0, 3) == 0);
         filt = ($urandom_range(0, 1) == 1);
         th   = int'($urandom_range(0, 100)) - 50;
         for (int k = 0; k < 8; k++)
            bt[k] = ($urandom_range(0, 31) == 0) ? -32768 : int'($urandom_range(0, 400)) - 200;
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0);
      end
      flush(4);
      inv = 0; filt = 0; th = 100; inh = 0;
   endtask

   task automatic test_saturate();
      do_reset();
      set_beat(0, 200, 0, 0, 0, 0, 0, 0);
      repeat (65540) cycle(1'b1, 1'b1);
      flush(4);
      n_chk++;
      if (tag_cnt_o !== 16'hFFFF) $display("FAIL cnt_saturate got %h exp ffff", tag_cnt_o);
      else n_pass++;
   endtask

   initial begin
      set_beat(0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_basic();
      test_first_beat();
      test_inhibit();
      test_back_to_back();
      test_invert_filter();
      test_arm_gap();
      test_reset_midflight();
      test_random();
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
